// File: rtl/proj_pkg.sv
// Shared definitions for the k-mer hashing path: base encoding, default k-mer
// geometry, the k-mer word type and the window-builder fill states.
package proj_pkg;

    localparam int KMER_BUFFER_HASHER_KMER_LEN  = 16;
    localparam int KMER_BUFFER_HASHER_BASE_BITS = 2;
    localparam int KMER_DATA_BITS =
        KMER_BUFFER_HASHER_KMER_LEN * KMER_BUFFER_HASHER_BASE_BITS;
    localparam int KMER_POS_W = 32;

    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_e;

    typedef logic [KMER_DATA_BITS-1:0] kmer_t;

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_STREAM = 1'b1
    } fill_state_e;

endpackage

// File: rtl/kmer_out_reg.sv
// Single-entry valid/ready output register carrying a k-mer word, its position
// and a last flag; payload is frozen while a beat is pending and not taken.
module kmer_out_reg #(
    parameter int DATA_W = 32,
    parameter int POS_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [POS_W-1:0]  i_pos,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_can_load,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [POS_W-1:0]  o_pos,
    output logic              o_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [POS_W-1:0]  r_pos;
    logic              r_last;

    // Room for a new beat when empty or when the pending beat leaves this cycle.
    assign o_can_load = !r_valid || i_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pos   <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pos   <= i_pos;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pos   = r_pos;
    assign o_last  = r_last;

endmodule

// File: rtl/kmer_window_builder.sv
// Sliding-window k-mer assembler feeding the hasher. Optional canonical k-mer
// output is enabled by defining CANONICAL_KMER_EN.
module kmer_window_builder
    import proj_pkg::*;
#(
    parameter int KMER_LEN         = KMER_BUFFER_HASHER_KMER_LEN,
    parameter int BASE_BITS        = KMER_BUFFER_HASHER_BASE_BITS,
    parameter int HASHER_DATA_BITS = KMER_LEN * BASE_BITS,
    parameter int POS_W            = KMER_POS_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        base_valid,
    output logic                        base_ready,
    input  logic [BASE_BITS-1:0]        base_data,
    input  logic                        base_is_n,
    input  logic                        base_last,
    output logic                        kmer_valid,
    input  logic                        kmer_ready,
    output logic [HASHER_DATA_BITS-1:0] kmer_data,
    output logic [POS_W-1:0]            kmer_pos,
    output logic                        kmer_last,
    output logic                        seq_done
);

    localparam int HDB    = HASHER_DATA_BITS;
    localparam int BB     = BASE_BITS;
    localparam int FILL_W = $clog2(KMER_LEN + 1);

    fill_state_e         r_state, w_state_next;
    logic [FILL_W-1:0]   r_fill, w_fill_next;
    logic [HDB-1:0]      r_win;
    logic [HDB-1:0]      w_win_next;
    logic [POS_W-1:0]    r_base_cnt;
    logic                r_seq_done;
    logic                w_accept;
    logic                w_emit;
    logic [HDB-1:0]      w_kmer_word;
    logic [POS_W-1:0]    w_kmer_pos;

    assign w_accept   = base_valid && base_ready;
    assign w_win_next = {r_win[HDB-BB-1:0], base_data};
    assign w_kmer_pos = r_base_cnt - POS_W'(KMER_LEN - 1);

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_fill_next  = r_fill;
        w_emit       = 1'b0;
        if (w_accept) begin
            if (base_is_n) begin
                w_fill_next  = '0;
                w_state_next = ST_FILL;
            end else if (r_state == ST_STREAM || r_fill == FILL_W'(KMER_LEN - 1)) begin
                w_emit       = 1'b1;
                w_fill_next  = FILL_W'(KMER_LEN);
                w_state_next = ST_STREAM;
            end else begin
                w_fill_next  = r_fill + 1'b1;
            end
            // End of sequence wins over everything: the next base starts afresh.
            if (base_last) begin
                w_fill_next  = '0;
                w_state_next = ST_FILL;
            end
        end
    end

    // NOTE: all control and datapath registers are reset so an asynchronous
    // reset mid-stream cannot leave a stale window behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FILL;
            r_fill     <= '0;
            r_win      <= '0;
            r_base_cnt <= '0;
            r_seq_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fill     <= w_fill_next;
            r_seq_done <= w_accept && base_last;
            if (w_accept && !base_is_n) begin
                r_win <= w_win_next;
            end
            if (w_accept) begin
                r_base_cnt <= base_last ? '0 : r_base_cnt + 1'b1;
            end
        end
    end

`ifdef CANONICAL_KMER_EN
    logic [HDB-1:0] r_rc;
    logic [HDB-1:0] w_rc_next;

    if (BASE_BITS != 2) begin : g_bad_base_bits
        $error("kmer_window_builder: CANONICAL_KMER_EN requires BASE_BITS == 2");
    end

    // Complementing a 2-bit base is a bitwise invert (A<->T, C<->G).
    assign w_rc_next   = {~base_data, r_rc[HDB-1:BB]};
    assign w_kmer_word = (w_win_next <= w_rc_next) ? w_win_next : w_rc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rc <= '0;
        end else if (w_accept && !base_is_n) begin
            r_rc <= w_rc_next;
        end
    end
`else
    assign w_kmer_word = w_win_next;
`endif

    kmer_out_reg #(
        .DATA_W (HDB),
        .POS_W  (POS_W)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_emit),
        .i_data     (w_kmer_word),
        .i_pos      (w_kmer_pos),
        .i_last     (base_last),
        .i_ready    (kmer_ready),
        .o_can_load (base_ready),
        .o_valid    (kmer_valid),
        .o_data     (kmer_data),
        .o_pos      (kmer_pos),
        .o_last     (kmer_last)
    );

    assign seq_done = r_seq_done;

endmodule

// File: tb/tb_kmer_window_builder.sv
// Self-checking bench for kmer_window_builder (KMER_LEN=4): directed table,
// multi-cycle corner sequences and randomized traffic against a queue model.
module tb_kmer_window_builder;
    import proj_pkg::*;

    localparam int K   = 4;
    localparam int BB  = 2;
    localparam int HDB = K * BB;
    localparam int PW  = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           base_valid = 1'b0;
    logic           base_ready;
    logic [BB-1:0]  base_data = '0;
    logic           base_is_n = 1'b0;
    logic           base_last = 1'b0;
    logic           kmer_valid;
    logic           kmer_ready = 1'b1;
    logic [HDB-1:0] kmer_data;
    logic [PW-1:0]  kmer_pos;
    logic           kmer_last;
    logic           seq_done;

    always #5 clk = ~clk;

    kmer_window_builder #(
        .KMER_LEN         (K),
        .BASE_BITS        (BB),
        .HASHER_DATA_BITS (HDB),
        .POS_W            (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .base_valid (base_valid),
        .base_ready (base_ready),
        .base_data  (base_data),
        .base_is_n  (base_is_n),
        .base_last  (base_last),
        .kmer_valid (kmer_valid),
        .kmer_ready (kmer_ready),
        .kmer_data  (kmer_data),
        .kmer_pos   (kmer_pos),
        .kmer_last  (kmer_last),
        .seq_done   (seq_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;

    // Reference model: the bases of the current run since the last N/sequence
    // start, the sequence index counter, and the expected output register.
    int             bases[$];
    logic [31:0]    m_cnt;
    logic           m_valid;
    logic [HDB-1:0] m_data;
    logic [PW-1:0]  m_pos;
    logic           m_last;
    logic           m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [HDB-1:0] kmer_of(input int q[$]);
        int fwd = 0;
        int rc  = 0;
        for (int i = 0; i < K; i++) fwd = fwd * 4 + q[i];
        for (int i = K - 1; i >= 0; i--) rc = rc * 4 + (3 - q[i]);
`ifdef CANONICAL_KMER_EN
        return HDB'((fwd <= rc) ? fwd : rc);
`else
        if (rc < 0) return '0;
        return HDB'(fwd);
`endif
    endfunction

    task automatic model_reset();
        bases.delete();
        m_cnt   = '0;
        m_valid = 1'b0;
        m_data  = '0;
        m_pos   = '0;
        m_last  = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic model_step(input logic acc);
        if (m_valid && kmer_ready) m_valid = 1'b0;
        m_done = 1'b0;
        if (acc) begin
            if (base_is_n) begin
                bases.delete();
            end else begin
                bases.push_back(int'(base_data));
                if (bases.size() > K) void'(bases.pop_front());
                if (bases.size() == K) begin
                    m_valid = 1'b1;
                    m_data  = kmer_of(bases);
                    m_pos   = m_cnt - 32'(K - 1);
                    m_last  = base_last;
                end
            end
            if (base_last) begin
                bases.delete();
                m_cnt  = '0;
                m_done = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    // One clock: inputs already driven; check ready, advance model, check outputs.
    task automatic tick();
        logic exp_rdy;
        #1;
        exp_rdy = !m_valid || kmer_ready;
        check("base_ready", 32'(base_ready), 32'(exp_rdy));
        if (kmer_valid && kmer_ready) n_hs++;
        model_step(base_valid && exp_rdy);
        @(posedge clk);
        #1;
        check("kmer_valid", 32'(kmer_valid), 32'(m_valid));
        if (m_valid) begin
            check("kmer_data", 32'(kmer_data), 32'(m_data));
            check("kmer_pos",  kmer_pos,       m_pos);
            check("kmer_last", 32'(kmer_last), 32'(m_last));
        end
        check("seq_done", 32'(seq_done), 32'(m_done));
    endtask

    task automatic send(input logic [1:0] b, input logic n, input logic l);
        base_valid = 1'b1;
        base_data  = b;
        base_is_n  = n;
        base_last  = l;
        tick();
    endtask

    task automatic idle(input int cycles);
        base_valid = 1'b0;
        base_is_n  = 1'b0;
        base_last  = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    typedef struct {
        logic           v;
        logic [1:0]     b;
        logic           n;
        logic           l;
        logic           ev;
        logic [HDB-1:0] ed;
        logic [31:0]    ep;
        logic           el;
        logic           esd;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Directed vectors: ACGTA(last), idle, then ACNGTAC(last), idle.
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 8'h1B, 32'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 8'h6C, 32'd1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 8'hB1, 32'd3, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0};

        model_reset();
        #12;
        check("reset_valid", 32'(kmer_valid), 32'd0);
        check("reset_data",  32'(kmer_data),  32'd0);
        check("reset_pos",   kmer_pos,        32'd0);
        check("reset_last",  32'(kmer_last),  32'd0);
        check("reset_done",  32'(seq_done),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            base_valid = tbl[i].v;
            base_data  = tbl[i].b;
            base_is_n  = tbl[i].n;
            base_last  = tbl[i].l;
            tick();
            check($sformatf("tbl%0d_valid", i), 32'(kmer_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_data", i), 32'(kmer_data), 32'(tbl[i].ed));
                check($sformatf("tbl%0d_pos", i),  kmer_pos,       tbl[i].ep);
                check($sformatf("tbl%0d_last", i), 32'(kmer_last), 32'(tbl[i].el));
            end
            check($sformatf("tbl%0d_done", i), 32'(seq_done), 32'(tbl[i].esd));
        end

        // Backpressure: first k-mer held for 5 cycles, then both delivered once.
        n_hs = 0;
        send(BASE_A, 0, 0); send(BASE_C, 0, 0); send(BASE_G, 0, 0); send(BASE_T, 0, 0);
        kmer_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(BASE_A, 0, 1);
            check("bp_base_ready", 32'(base_ready), 32'd0);
            check("bp_hold_data",  32'(kmer_data),  32'h1B);
            check("bp_hold_valid", 32'(kmer_valid), 32'd1);
        end
        kmer_ready = 1'b1;
        send(BASE_A, 0, 1);
        check("bp_second_data", 32'(kmer_data), 32'h6C);
        idle(2);
        check("bp_handshakes", 32'(n_hs), 32'd2);

        // Short sequence gives only seq_done; next sequence restarts at pos 0.
        send(BASE_A, 0, 0);
        send(BASE_C, 0, 1);
        check("short_done",  32'(seq_done),   32'd1);
        check("short_valid", 32'(kmer_valid), 32'd0);
        send(BASE_A, 0, 0); send(BASE_C, 0, 0); send(BASE_G, 0, 0); send(BASE_T, 0, 0);
        check("restart_data", 32'(kmer_data), 32'h1B);
        check("restart_pos",  kmer_pos,       32'd0);

        // N base carrying last: no k-mer but seq_done still pulses.
        send(BASE_G, 1, 1);
        check("n_last_done",  32'(seq_done),   32'd1);
        check("n_last_valid", 32'(kmer_valid), 32'd0);

        // Asynchronous reset mid-stream drops the partial window.
        send(BASE_A, 0, 0); send(BASE_C, 0, 0); send(BASE_G, 0, 0);
        base_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(kmer_valid), 32'd0);
        check("midrst_data",  32'(kmer_data),  32'd0);
        check("midrst_pos",   kmer_pos,        32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(BASE_T, 0, 0); send(BASE_A, 0, 0); send(BASE_C, 0, 0); send(BASE_G, 0, 0);
`ifdef CANONICAL_KMER_EN
        check("after_rst_data", 32'(kmer_data), 32'h6C);
`else
        check("after_rst_data", 32'(kmer_data), 32'hC6);
`endif
        check("after_rst_pos", kmer_pos, 32'd0);
        send(BASE_A, 0, 1);

        // Palindrome-free extremes: TTTT, then CGTA.
        send(BASE_T, 0, 0); send(BASE_T, 0, 0); send(BASE_T, 0, 0); send(BASE_T, 0, 1);
`ifdef CANONICAL_KMER_EN
        check("tttt_data", 32'(kmer_data), 32'h00);
`else
        check("tttt_data", 32'(kmer_data), 32'hFF);
`endif
        send(BASE_C, 0, 0); send(BASE_G, 0, 0); send(BASE_T, 0, 0); send(BASE_A, 0, 1);
        check("cgta_data", 32'(kmer_data), 32'h6C);

        // Randomized traffic with N bases, sequence ends and backpressure.
        for (int i = 0; i < 3000; i++) begin
            base_valid = ($urandom_range(0, 3) != 0);
            base_data  = 2'($urandom_range(0, 3));
            base_is_n  = ($urandom_range(0, 19) == 0);
            base_last  = ($urandom_range(0, 29) == 0);
            kmer_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        kmer_ready = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
